// File: rtl/me_pkg.sv
// Shared types and defaults for the integer ME CTU scheduler.
package me_pkg;

  localparam int unsigned DONE_COL_DEF    = 31;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;
  localparam int unsigned CTU_W_DEF       = 8;
  localparam int unsigned SCC_W           = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    START = 3'd2,
    ARM   = 3'd3,
    RUN   = 3'd4,
    NEXT  = 3'd5
  } me_sched_state_t;

endpackage

// File: rtl/me_ctu_scheduler_if.sv
// Frame-control, loader and PE_array_ctrl handshake bundle for the CTU scheduler.
interface me_ctu_scheduler_if #(
  parameter int unsigned CTU_W = me_pkg::CTU_W_DEF
) ();

  logic                       frame_start;
  logic [CTU_W-1:0]           frame_w_ctu;
  logic [CTU_W-1:0]           frame_h_ctu;
  logic                       ref_load_req;
  logic                       ref_load_ack;
  logic                       begin_prepare;
  logic [me_pkg::SCC_W-1:0]   search_column_count;
  logic [CTU_W-1:0]           ctu_x;
  logic [CTU_W-1:0]           ctu_y;
  logic                       ctu_done;
  logic                       frame_done;
  logic                       busy;
  logic                       err_timeout;

  // Scheduler side
  modport slave (
    input  frame_start, frame_w_ctu, frame_h_ctu, ref_load_ack, search_column_count,
    output ref_load_req, begin_prepare, ctu_x, ctu_y, ctu_done, frame_done, busy, err_timeout
  );

  // Frame control / loader / PE side
  modport master (
    output frame_start, frame_w_ctu, frame_h_ctu, ref_load_ack, search_column_count,
    input  ref_load_req, begin_prepare, ctu_x, ctu_y, ctu_done, frame_done, busy, err_timeout
  );

endinterface

// File: rtl/me_ctu_raster_cnt.sv
// Raster-order CTU position counter with a last-CTU flag.
module me_ctu_raster_cnt #(
  parameter int unsigned CTU_W = me_pkg::CTU_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [CTU_W-1:0] w_last_i,
  input  logic [CTU_W-1:0] h_last_i,
  output logic [CTU_W-1:0] x_o,
  output logic [CTU_W-1:0] y_o,
  output logic             last_c_o
);

  logic [CTU_W-1:0] x_q, x_d;
  logic [CTU_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q < w_last_i) begin
        x_d = x_q + CTU_W'(1);
      end else if (y_q < h_last_i) begin
        x_d = '0;
        y_d = y_q + CTU_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign last_c_o = (x_q >= w_last_i) && (y_q >= h_last_i);

endmodule

// File: rtl/me_ctu_scheduler.sv
// Frame-level CTU sequencer: window request, PE kick-off, completion/timeout tracking.
module me_ctu_scheduler
  import me_pkg::*;
#(
  parameter int unsigned DONE_COL    = DONE_COL_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CTU_W       = CTU_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  me_ctu_scheduler_if.slave bus
);

  localparam int unsigned     WD_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [SCC_W-1:0] DONE_VAL = SCC_W'(DONE_COL);

  me_sched_state_t  state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CTU_W-1:0] w_last_q, w_last_d;
  logic [CTU_W-1:0] h_last_q, h_last_d;
  logic             req_q, req_d;
  logic             bp_q, bp_d;
  logic             ctu_done_q, ctu_done_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             cnt_clear_c, cnt_adv_c, last_ctu_c, scc_done_c;
  logic [CTU_W-1:0] ctu_x, ctu_y;
  logic [WD_W-1:0]  wd_inc_c;

  // A zero dimension is treated as one CTU, so the last index is zero.
  function automatic logic [CTU_W-1:0] dim_last(input logic [CTU_W-1:0] d);
    return (d == '0) ? '0 : d - CTU_W'(1);
  endfunction

  assign scc_done_c = (bus.search_column_count == DONE_VAL);
  assign wd_inc_c   = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);

  me_ctu_raster_cnt #(.CTU_W(CTU_W)) u_raster (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (cnt_clear_c),
    .advance_i (cnt_adv_c),
    .w_last_i  (w_last_q),
    .h_last_i  (h_last_q),
    .x_o       (ctu_x),
    .y_o       (ctu_y),
    .last_c_o  (last_ctu_c)
  );

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    w_last_d     = w_last_q;
    h_last_d     = h_last_q;
    err_d        = err_q;
    ctu_done_d   = 1'b0;
    frame_done_d = 1'b0;
    cnt_clear_c  = 1'b0;
    cnt_adv_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          w_last_d    = dim_last(bus.frame_w_ctu);
          h_last_d    = dim_last(bus.frame_h_ctu);
          cnt_clear_c = 1'b1;
          err_d       = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.ref_load_ack) state_d = START;
      end
      START: begin
        wd_d    = '0;
        state_d = ARM;
      end
      // Skip a terminal column count left over from the previous CTU.
      ARM: begin
        wd_d = wd_inc_c;
        if (!scc_done_c) state_d = RUN;
      end
      RUN: begin
        if (scc_done_c) begin
          ctu_done_d = 1'b1;
          state_d    = NEXT;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_inc_c;
        end
      end
      NEXT: begin
        if (last_ctu_c) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_adv_c = 1'b1;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ);
    bp_d   = (state_d == START);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      w_last_q     <= '0;
      h_last_q     <= '0;
      req_q        <= 1'b0;
      bp_q         <= 1'b0;
      ctu_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      w_last_q     <= w_last_d;
      h_last_q     <= h_last_d;
      req_q        <= req_d;
      bp_q         <= bp_d;
      ctu_done_q   <= ctu_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.ref_load_req  = req_q;
  assign bus.begin_prepare = bp_q;
  assign bus.ctu_x         = ctu_x;
  assign bus.ctu_y         = ctu_y;
  assign bus.ctu_done      = ctu_done_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.busy          = busy_q;
  assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_me_ctu_scheduler.sv
// Scoreboard bench for me_ctu_scheduler: randomized frames, raster-order event model, watchdog instance.
module tb_me_ctu_scheduler;

  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_ctu_scheduler_if #(.CTU_W(CW)) bus ();
  me_ctu_scheduler_if #(.CTU_W(CW)) wbus ();

  me_ctu_scheduler #(.DONE_COL(31), .TIMEOUT_CYC(4096), .CTU_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  me_ctu_scheduler #(.DONE_COL(31), .TIMEOUT_CYC(16), .CTU_W(CW)) dut_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus)
  );

  typedef enum int {EV_BP = 0, EV_DONE = 1, EV_FRAME = 2} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       x;
    int       y;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  wd_fd_cnt = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.ref_load_req;
      1: return bus.begin_prepare;
      2: return bus.ctu_done;
      3: return bus.frame_done;
      4: return wbus.err_timeout;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void mon_pop(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected pulse: got event %0d at (%0d,%0d), expected none", int'(k),
               bus.ctu_x, bus.ctu_y);
      return;
    end
    e = exp_q.pop_front();
    chk("event kind", int'(k), int'(e.kind));
    chk("event ctu_x", bus.ctu_x, e.x);
    chk("event ctu_y", bus.ctu_y, e.y);
  endfunction

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (bus.begin_prepare) mon_pop(EV_BP);
    if (bus.ctu_done) mon_pop(EV_DONE);
    if (bus.frame_done) begin
      mon_pop(EV_FRAME);
      chk("busy falls with frame_done", bus.busy, 0);
    end
    if (wbus.frame_done) wd_fd_cnt++;
  end

  task automatic wait_for(input int sel, input int budget, input string name,
                          output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      if (sig(sel)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles, expected signal high", name, budget);
    end
  endtask

  // Reference model: the frame is W*H CTUs in raster order, zero dims meaning one.
  function automatic void push_frame(input int w, input int h);
    int wn, hn;
    ev_t e;
    wn = (w == 0) ? 1 : w;
    hn = (h == 0) ? 1 : h;
    for (int y = 0; y < hn; y++) begin
      for (int x = 0; x < wn; x++) begin
        e.kind = EV_BP;   e.x = x; e.y = y; exp_q.push_back(e);
        e.kind = EV_DONE; e.x = x; e.y = y; exp_q.push_back(e);
      end
    end
    e.kind = EV_FRAME; e.x = wn - 1; e.y = hn - 1;
    exp_q.push_back(e);
  endfunction

  task automatic start_frame(input int w, input int h);
    bus.frame_w_ctu = CW'(w);
    bus.frame_h_ctu = CW'(h);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("frame_start->ref_load_req", bus.ref_load_req, 1);
    chk("busy after frame_start", bus.busy, 1);
    chk("err_timeout after frame_start", bus.err_timeout, 0);
  endtask

  // Plays loader and PE_array_ctrl for one CTU.
  task automatic serve_ctu(input bit last, input int ack_dly, input int stale, input int run_len,
                           input bit inject, input bit rst_mid);
    bit ok;
    int cyc;
    wait_for(0, 50, "wait ref_load_req", ok, cyc);
    if (!ok) return;
    repeat (ack_dly) @(negedge clk);
    chk("ref_load_req held until ack", bus.ref_load_req, 1);
    bus.ref_load_ack = 1'b1;
    @(negedge clk);
    bus.ref_load_ack = 1'b0;
    chk("ref_load_ack->begin_prepare", bus.begin_prepare, 1);
    chk("ref_load_req dropped", bus.ref_load_req, 0);
    bus.search_column_count = 5'd31;
    repeat (stale) @(negedge clk);
    chk("stale DONE_COL ignored", bus.ctu_done, 0);
    bus.search_column_count = 5'd5;
    if (rst_mid) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset busy", bus.busy, 0);
      chk("reset ctu_x", bus.ctu_x, 0);
      chk("reset ctu_y", bus.ctu_y, 0);
      chk("reset ctu_done", bus.ctu_done, 0);
      chk("reset frame_done", bus.frame_done, 0);
      chk("reset ref_load_req", bus.ref_load_req, 0);
      chk("scoreboard drained at reset", exp_q.size(), 0);
      bus.search_column_count = 5'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end
    for (int c = 0; c < run_len; c++) begin
      @(negedge clk);
      if (inject && c == 1) begin
        bus.frame_start  = 1'b1;
        bus.ref_load_ack = 1'b1;
        bus.frame_w_ctu  = CW'($urandom_range(5, 9));
        bus.frame_h_ctu  = CW'($urandom_range(5, 9));
      end else begin
        bus.frame_start  = 1'b0;
        bus.ref_load_ack = 1'b0;
      end
      bus.search_column_count = 5'($urandom_range(0, 30));
    end
    bus.frame_start  = 1'b0;
    bus.ref_load_ack = 1'b0;
    bus.search_column_count = 5'd31;
    @(negedge clk);
    chk("DONE_COL->ctu_done", bus.ctu_done, 1);
    @(negedge clk);
    if (last) begin
      chk("ctu_done->frame_done", bus.frame_done, 1);
      chk("busy after frame_done", bus.busy, 0);
    end else begin
      chk("ctu_done->next ref_load_req", bus.ref_load_req, 1);
    end
  endtask

  task automatic run_frame(input int w, input int h, input bit fixed, input bit inject);
    int n;
    n = ((w == 0) ? 1 : w) * ((h == 0) ? 1 : h);
    push_frame(w, h);
    start_frame(w, h);
    for (int i = 0; i < n; i++) begin
      if (fixed) serve_ctu(i == n - 1, 3, 1, 98, inject, 1'b0);
      else serve_ctu(i == n - 1, $urandom_range(0, 3), $urandom_range(1, 4),
                     $urandom_range(4, 60), inject, 1'b0);
    end
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int cyc;
    ev_t e;
    bus.frame_start = 1'b0;  bus.frame_w_ctu = '0;  bus.frame_h_ctu = '0;
    bus.ref_load_ack = 1'b0; bus.search_column_count = '0;
    wbus.frame_start = 1'b0; wbus.frame_w_ctu = '0; wbus.frame_h_ctu = '0;
    wbus.ref_load_ack = 1'b0; wbus.search_column_count = '0;

    repeat (3) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst ref_load_req", bus.ref_load_req, 0);
    chk("rst begin_prepare", bus.begin_prepare, 0);
    chk("rst ctu_x", bus.ctu_x, 0);
    chk("rst ctu_y", bus.ctu_y, 0);
    chk("rst ctu_done", bus.ctu_done, 0);
    chk("rst frame_done", bus.frame_done, 0);
    chk("rst err_timeout", bus.err_timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2x2 with fixed timing, 1x1 from zero dims, 2x2 with ignored strobes
    run_frame(2, 2, 1'b1, 1'b0);
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(2, 2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(0, 4), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));

    // Reset while the second CTU of a 3x2 frame is running
    e.kind = EV_BP;   e.x = 0; e.y = 0; exp_q.push_back(e);
    e.kind = EV_DONE; e.x = 0; e.y = 0; exp_q.push_back(e);
    e.kind = EV_BP;   e.x = 1; e.y = 0; exp_q.push_back(e);
    start_frame(3, 2);
    serve_ctu(1'b0, 1, 1, 10, 1'b0, 1'b0);
    serve_ctu(1'b0, 1, 2, 10, 1'b0, 1'b1);
    run_frame(1, 2, 1'b0, 1'b0);

    // Watchdog expiry on the short-timeout instance
    wbus.frame_w_ctu = CW'(1);
    wbus.frame_h_ctu = CW'(1);
    wbus.frame_start = 1'b1;
    @(negedge clk);
    wbus.frame_start = 1'b0;
    chk("wd frame_start->ref_load_req", wbus.ref_load_req, 1);
    wbus.ref_load_ack = 1'b1;
    @(negedge clk);
    wbus.ref_load_ack = 1'b0;
    chk("wd begin_prepare", wbus.begin_prepare, 1);
    wbus.search_column_count = 5'd5;
    wait_for(4, 60, "watchdog expiry", ok, cyc);
    if (ok) begin
      chk("watchdog expiry not early", (cyc >= 12) ? 1 : 0, 1);
      chk("watchdog expiry not late", (cyc <= 24) ? 1 : 0, 1);
    end
    chk("timeout busy", wbus.busy, 0);
    chk("timeout ctu_done", wbus.ctu_done, 0);
    repeat (4) @(negedge clk);
    chk("err_timeout sticky", wbus.err_timeout, 1);
    chk("no frame_done on timeout", wd_fd_cnt, 0);
    wbus.frame_start = 1'b1;
    @(negedge clk);
    wbus.frame_start = 1'b0;
    chk("err_timeout cleared by frame_start", wbus.err_timeout, 0);
    chk("wd restart ref_load_req", wbus.ref_load_req, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard empty at end", exp_q.size(), 0);
    chk("main err_timeout never set", bus.err_timeout, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
